// File: rtl/card_dealer.sv
// ---------------------------------------------------------------------------
// card_dealer
//   Deck source for the Blackjack datapath. Holds a 52-card deck, deals one
//   randomly chosen undealt card per draw request, and presents it on the
//   newCard/cardIn pair used by the sprite path. Dealt cards are tracked in a
//   bitmap until a shuffle returns every card to the deck.
//
//   Optional feature macro: CARD_DEALER_FIXED_ORDER_EN
//     defined   -> candidate index is always 0, so cards come out in idx
//                  order 0..51 (deterministic demo/bench mode)
//     undefined -> candidate index is taken from the 8-bit LFSR
//
// Parameters
//   LFSR_SEED   LFSR load value on reset (0 is replaced by 8'h01)
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous active-high reset
//   shuffle     in   pulse: return all 52 cards to the deck
//   draw        in   pulse: request one card
//   newCard     out  one-cycle strobe, cardIn valid in the same cycle
//   cardIn      out  {suit[1:0], value[3:0]}, value 1..13
//   busy        out  high while searching for an undealt card
//   deck_empty  out  high when no cards remain
//   cards_left  out  number of undealt cards, 0..52
// ---------------------------------------------------------------------------
module card_dealer #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       shuffle,
  input  logic       draw,
  output logic       newCard,
  output logic [5:0] cardIn,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [5:0] DECK_SIZE = 6'd52;
  localparam logic [5:0] LAST_IDX  = 6'd51;

  typedef enum logic {
    S_IDLE,
    S_SEARCH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_lfsr;
  logic [51:0] r_used;
  logic [51:0] w_used_nxt;
  logic [5:0]  r_idx;
  logic [5:0]  w_idx_nxt;
  logic [5:0]  r_cards_left;
  logic [5:0]  w_cards_left_nxt;
  logic [5:0]  r_card;
  logic [5:0]  w_card_nxt;
  logic        r_new;
  logic        w_new_nxt;
  logic [5:0]  w_cand;
  logic        w_lfsr_fb;

  // Deck index -> {suit, value}. value = idx - 13*suit + 1.
  function automatic logic [5:0] f_encode(input logic [5:0] idx);
    logic [1:0] suit;
    logic [5:0] val;
    if (idx < 6'd13) begin
      suit = 2'd0;
      val  = idx + 6'd1;
    end else if (idx < 6'd26) begin
      suit = 2'd1;
      val  = idx - 6'd12;
    end else if (idx < 6'd39) begin
      suit = 2'd2;
      val  = idx - 6'd25;
    end else begin
      suit = 2'd3;
      val  = idx - 6'd38;
    end
    return {suit, val[3:0]};
  endfunction

  // x^8+x^6+x^5+x^4+1 Fibonacci form; from a non-zero seed it never hits 0.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

`ifdef CARD_DEALER_FIXED_ORDER_EN
  assign w_cand = 6'd0;
`else
  // Fold 52..63 back into range so every LFSR value maps to a legal index.
  assign w_cand = (r_lfsr[5:0] >= DECK_SIZE) ? (r_lfsr[5:0] - DECK_SIZE)
                                             : r_lfsr[5:0];
`endif

  // LFSR free-runs every cycle, independent of the FSM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_lfsr <= SEED_EFF;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_used       <= '0;
      r_idx        <= '0;
      r_cards_left <= DECK_SIZE;
      r_card       <= '0;
      r_new        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_used       <= w_used_nxt;
      r_idx        <= w_idx_nxt;
      r_cards_left <= w_cards_left_nxt;
      r_card       <= w_card_nxt;
      r_new        <= w_new_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_used_nxt       = r_used;
    w_idx_nxt        = r_idx;
    w_cards_left_nxt = r_cards_left;
    w_card_nxt       = r_card;
    w_new_nxt        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Shuffle wins over a simultaneous draw; the draw is dropped.
        if (shuffle) begin
          w_used_nxt       = '0;
          w_cards_left_nxt = DECK_SIZE;
        end else if (draw && (r_cards_left != 6'd0)) begin
          w_idx_nxt   = w_cand;
          w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // Shuffle aborts the search even if the probed card is free.
        if (shuffle) begin
          w_used_nxt       = '0;
          w_cards_left_nxt = DECK_SIZE;
          w_state_nxt      = S_IDLE;
        end else if (!r_used[r_idx]) begin
          w_used_nxt[r_idx] = 1'b1;
          w_card_nxt        = f_encode(r_idx);
          w_new_nxt         = 1'b1;
          w_cards_left_nxt  = r_cards_left - 6'd1;
          w_state_nxt       = S_IDLE;
        end else begin
          // Linear probe with wrap; cards_left > 0 on entry bounds this.
          w_idx_nxt = (r_idx == LAST_IDX) ? 6'd0 : r_idx + 6'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign newCard    = r_new;
  assign cardIn     = r_card;
  assign busy       = (r_state == S_SEARCH);
  assign deck_empty = (r_cards_left == 6'd0);
  assign cards_left = r_cards_left;

endmodule

// File: doc/card_dealer.md
# card_dealer

Deck source for the Blackjack FPGA datapath. It holds a 52-card deck, deals one randomly chosen undealt card per request, and drives the `newCard`/`cardIn` pair consumed by the card-value and suit registers in the VGA sprite path. It tracks dealt cards in a bitmap until a shuffle restores the full deck. It sits between the game FSM, which issues `draw` and `shuffle`, and the sprite-drawing logic.

## Interface
- `LFSR_SEED`, default 8'hA5: LFSR load value on reset; a seed of 0 is replaced by 8'h01.
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `shuffle`  in  1  single-cycle pulse; returns all 52 cards to the deck.
- `draw`  in  1  single-cycle request for one card.
- `newCard`  out  1  single-cycle strobe; `cardIn` is valid in the same cycle.
- `cardIn`  out  6  {suit[1:0], value[3:0]}; value is 1..13 (1=Ace, 11=J, 12=Q, 13=K).
- `busy`  out  1  high while a search is in progress.
- `deck_empty`  out  1  high when `cards_left`==0.
- `cards_left`  out  6  number of undealt cards, 0..52.

## Operation
- Deck index is `idx` 0..51.
  - suit = 0 if idx<13, 1 if idx<26, 2 if idx<39, else 3.
  - value = idx − 13·suit + 1.
- 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every cycle including IDLE. It never reaches 0.
- `used[51:0]` bitmap: 1 means the card has been dealt.
- FSM states: IDLE, SEARCH.
- IDLE, `shuffle`=1: clear `used`, set `cards_left`=52, stay in IDLE. `draw` in the same cycle is dropped.
- IDLE, `draw`=1 and `cards_left`>0:
  - Candidate c = lfsr[5:0]; if c≥52, use c−52.
  - Load `idx`=c and go to SEARCH.
- IDLE, `draw`=1 and `cards_left`==0: ignored. No strobe, state does not change.
- SEARCH, `used[idx]`==0:
  - Set `used[idx]`, register `cardIn` from idx, pulse `newCard`, decrement `cards_left`, go to IDLE.
- SEARCH, `used[idx]`==1: idx = (idx==51) ? 0 : idx+1; stay in SEARCH.
  - Termination is guaranteed because `cards_left`>0 on entry.
- SEARCH, `shuffle`=1: abort. Clear `used`, set `cards_left`=52, go to IDLE, no `newCard`.
- `draw` during SEARCH is ignored; it is not queued.
- `cardIn` holds the last dealt card until the next deal.

## Timing
- Reset values: state IDLE, `newCard`=0, `cardIn`=0, `busy`=0, `cards_left`=52, `deck_empty`=0, `used`=0, lfsr=`LFSR_SEED`.
- `draw` sampled at edge k, first probe free:
  - `busy` is high in cycle k+1.
  - `newCard`/`cardIn` are valid in cycle k+2; this is the minimum latency of 2.
- Maximum latency is 53 cycles: 51 occupied probes plus 2.
- `busy` = (state==SEARCH), a registered state decode. It falls in the same cycle `newCard` rises.
- `cards_left` and `deck_empty` update in the `newCard` cycle.
- Back-to-back: `draw` asserted in the `newCard` cycle is accepted. Sustained throughput is one card per 2 cycles at best.
- Shuffle takes effect the cycle after it is sampled; `cards_left` reads 52 then.
- `Reset` overrides everything, including mid-SEARCH: no `newCard`, full deck restored.

## Configuration
- `CARD_DEALER_FIXED_ORDER_EN`
  - Defined: the candidate index is always 0, so cards are dealt in idx order 0,1,…,51 (deterministic, for bench and demo). The LFSR is still present but unused.
  - Undefined: the candidate comes from the LFSR as described above.

## Test plan
- Reset asserted 2 cycles, then released → `cards_left`=52, `cardIn`=6'h00, `newCard`=0, `busy`=0, `deck_empty`=0.
- FIXED_ORDER, draw at edge k:
  - `newCard`=1 at k+2 with `cardIn`=6'b00_0001.
  - 13th draw gives 6'b00_1101; 14th gives 6'b01_0001; 52nd gives 6'b11_1101.
- Random mode, 52 draws → 52 distinct `cardIn` codes, every value in 1..13, each suit exactly 13 times. Then `cards_left`=0, `deck_empty`=1; a 53rd draw gives no `newCard` within 60 cycles and `busy` stays 0.
- FIXED_ORDER, deal 5 cards, shuffle, then draw → `cards_left`=52 after the shuffle; next `cardIn`=6'b00_0001 with latency 2.
- `shuffle` and `draw` in the same IDLE cycle → no `newCard`, `cards_left`=52. Shuffle during SEARCH (50 cards dealt, FIXED_ORDER) → no `newCard`, `cards_left`=52.
- `Reset` in the SEARCH cycle → next cycle IDLE, `newCard`=0, `cards_left`=52, `cardIn`=0.
